// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus and aligns/extends data-SRAM load words.
// It drives the WB bus and the same-cycle MEM->RF forwarding bus.
module mem_stage #(
  parameter int STALL_W      = 6,
  parameter int EX_TO_MEM_WD = 84,
  parameter int MEM_TO_WB_WD = 70,
  parameter int MEM_TO_RF_WD = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

  logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [31:0]             rdata_hold_q, rdata_hold_d;

  logic [5:0]  ld_st_op;
  logic [1:0]  addr_lo;
  logic [31:0] mem_pc;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic        is_load;
  logic [31:0] eff_rdata;
  logic [31:0] rf_wdata;

  assign {ld_st_op, addr_lo, mem_pc, data_sram_en, data_sram_wen,
          sel_rf_res, rf_we, rf_waddr, ex_result} = bus_q;

  assign is_load   = data_sram_en && (data_sram_wen == 4'b0000) && (ld_st_op[5:3] == 3'b100);
  assign eff_rdata = hold_valid_q ? rdata_hold_q : data_sram_rdata;

  function automatic logic [31:0] load_align(input logic [5:0]  op,
                                             input logic [1:0]  lo,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[7:0];
    case (lo)
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      6'b100000: load_align = {{24{b[7]}}, b};
      6'b100100: load_align = {24'd0, b};
      6'b100001: load_align = {{16{h[15]}}, h};
      6'b100101: load_align = {16'd0, h};
      default:   load_align = word;
    endcase
  endfunction

  assign rf_wdata = (sel_rf_res && is_load) ? load_align(ld_st_op, addr_lo, eff_rdata)
                                            : ex_result;

  assign mem_to_wb_bus = {mem_pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus = {rf_we, rf_waddr, rf_wdata};

  // A bubble or a fresh instruction always drops any captured read word.
  always_comb begin
    bus_d        = bus_q;
    hold_valid_d = hold_valid_q;
    rdata_hold_d = rdata_hold_q;
    if (!stall[3]) begin
      bus_d        = ex_to_mem_bus;
      hold_valid_d = 1'b0;
    end else if (!stall[4]) begin
      bus_d        = '0;
      hold_valid_d = 1'b0;
    end else if (is_load && !hold_valid_q) begin
      rdata_hold_d = data_sram_rdata;
      hold_valid_d = 1'b1;
    end
  end

  // Stage register boundary: EX -> MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q        <= '0;
      hold_valid_q <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      bus_q        <= bus_d;
      hold_valid_q <= hold_valid_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

endmodule
